spi_master_fifo: RTL

Next-generation SPI controller peripheral on the peripheral bus: one SPI engine driving CS_COUNT chip selects, with programmable clock divider, CPOL/CPHA mode, and TX/RX FIFOs of FIFO_DEPTH words.
- Replaces the single-register SPI device used inside the SPI peripheral wrapper.
- Software queues words back-to-back; the engine streams them without per-word bus intervention.
- Sits behind the standard peripheral bus; read data goes to the peripheral read mux via requestOutput.

---
 rtl/spi_master_pkg.sv | 32 +++
 rtl/spi_sync_fifo.sv | 59 +++++
 rtl/spi_master_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: register map, CONFIG/STATUS bit
// positions and the engine state encoding.
package spi_master_pkg;

  localparam logic [11:0] REG_CONFIG = 12'h000;
  localparam logic [11:0] REG_STATUS = 12'h004;
  localparam logic [11:0] REG_DATA   = 12'h008;

  localparam int CFG_CPOL      = 16;
  localparam int CFG_CPHA      = 17;
  localparam int CFG_ENABLE    = 18;
  localparam int CFG_CS_SEL    = 20;
  localparam int CFG_CS_AUTO   = 22;
  localparam int CFG_CS_MANUAL = 23;

  localparam int STS_BUSY     = 0;
  localparam int STS_TX_FULL  = 1;
  localparam int STS_TX_EMPTY = 2;
  localparam int STS_RX_FULL  = 3;
  localparam int STS_RX_EMPTY = 4;
  localparam int STS_RX_OVF   = 5;
  localparam int STS_TX_CNT   = 8;
  localparam int STS_RX_CNT   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with a combinational head; pushes into a full FIFO and
// pops from an empty one are ignored.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array, no reset needed: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master peripheral: bus register file, TX/RX FIFOs and a CPOL/CPHA
// shift engine that streams queued words under one chip-select assertion.
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter logic [7:0] ID          = 8'h01,
  parameter int         CS_COUNT    = 2,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         DATA_WIDTH  = 8,
  parameter int         CLOCK_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 peripheralBus_we,
  input  logic                 peripheralBus_oe,
  output logic                 peripheralBus_busy,
  input  logic [23:0]          peripheralBus_address,
  input  logic [3:0]           peripheralBus_byteSelect,
  input  logic [31:0]          peripheralBus_dataWrite,
  output logic [31:0]          peripheralBus_dataRead,
  output logic                 requestOutput,
  output logic                 spi_en,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [CS_COUNT-1:0]  spi_cs
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [31:0] CFG_MASK = 32'((64'd1 << CLOCK_WIDTH) - 64'd1) | 32'h00F7_0000;

  spi_state_e state_r, state_next;

  logic [31:0] config_r, wmask_s, status_s, rdata_s;
  logic [11:0] offset_s;
  logic sel_s, wr_s, is_cfg_s, is_sts_s, is_data_s;
  logic rx_ovf_r, tick_s, load_s, word_done_s, sample_s, shift_s;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DATA_WIDTH-1:0] tx_dout, rx_dout, shift_r, rx_r, rx_word_s;
  logic [CLOCK_WIDTH-1:0] div_cnt_r, cur_div_r;
  logic [EW-1:0] edge_cnt_r;
  logic cur_cpol_r, cur_cpha_r, sclk_r, mosi_r;
  logic [CS_COUNT-1:0] cs_r, cs_next_s;

  wire [CLOCK_WIDTH-1:0] cfg_div   = config_r[CLOCK_WIDTH-1:0];
  wire                   cfg_cpol  = config_r[CFG_CPOL];
  wire                   cfg_cpha  = config_r[CFG_CPHA];
  wire                   cfg_en    = config_r[CFG_ENABLE];
  wire [1:0]             cfg_sel   = config_r[CFG_CS_SEL +: 2];
  wire                   cfg_auto  = config_r[CFG_CS_AUTO];
  wire                   cfg_man   = config_r[CFG_CS_MANUAL];

  assign offset_s  = peripheralBus_address[11:0];
  assign sel_s     = (peripheralBus_address[23:20] == 4'h0) && (peripheralBus_address[19:12] == ID);
  assign is_cfg_s  = (offset_s == REG_CONFIG);
  assign is_sts_s  = (offset_s == REG_STATUS);
  assign is_data_s = (offset_s == REG_DATA);
  assign wmask_s   = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                      {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};

  assign peripheralBus_busy = sel_s && peripheralBus_we && is_data_s && tx_full;
  assign wr_s          = sel_s && peripheralBus_we && !peripheralBus_busy;
  assign requestOutput = sel_s && peripheralBus_oe && (is_cfg_s || is_sts_s || is_data_s);

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_s && is_data_s && (|peripheralBus_byteSelect)),
    .pop   (load_s),
    .din   (DATA_WIDTH'(peripheralBus_dataWrite & wmask_s)),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done_s && !rx_full),
    .pop   (requestOutput && is_data_s),
    .din   (rx_word_s),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // CONFIG register and sticky RX overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      config_r <= 32'h0000_0000;
      rx_ovf_r <= 1'b0;
    end else begin
      if (wr_s && is_cfg_s) begin
        config_r <= ((config_r & ~wmask_s) | (peripheralBus_dataWrite & wmask_s)) & CFG_MASK;
      end
      if (word_done_s && rx_full) begin
        rx_ovf_r <= 1'b1;
      end else if (wr_s && is_sts_s && wmask_s[STS_RX_OVF] && peripheralBus_dataWrite[STS_RX_OVF]) begin
        rx_ovf_r <= 1'b0;
      end
    end
  end

  // STATUS assembly and register read mux.
  always_comb begin
    status_s = 32'h0000_0000;
    status_s[STS_BUSY]          = (state_r != IDLE);
    status_s[STS_TX_FULL]       = tx_full;
    status_s[STS_TX_EMPTY]      = tx_empty;
    status_s[STS_RX_FULL]       = rx_full;
    status_s[STS_RX_EMPTY]      = rx_empty;
    status_s[STS_RX_OVF]        = rx_ovf_r;
    status_s[STS_TX_CNT +: 8]   = 8'(tx_count);
    status_s[STS_RX_CNT +: 8]   = 8'(rx_count);
    rdata_s = 32'hFFFF_FFFF;
    if (requestOutput) begin
      case (offset_s)
        REG_CONFIG: rdata_s = config_r;
        REG_STATUS: rdata_s = status_s;
        REG_DATA:   rdata_s = rx_empty ? 32'h0000_0000 : 32'(rx_dout);
        default:    rdata_s = 32'hFFFF_FFFF;
      endcase
    end else begin
      rdata_s = 32'hFFFF_FFFF;
    end
  end

  assign peripheralBus_dataRead = rdata_s;

  // Half-period tick; the divider restarts on every tick so each phase is clkDiv+1 cycles.
  assign tick_s      = (state_r != IDLE) && (div_cnt_r == cur_div_r);
  assign sample_s    = ~edge_cnt_r[0] ^ cur_cpha_r;
  assign shift_s     = !sample_s && (edge_cnt_r != '0);
  assign rx_word_s   = cur_cpha_r ? {rx_r[DATA_WIDTH-2:0], spi_miso} : rx_r;

  // Engine next-state logic; back-to-back words reload straight into SHIFT.
  always_comb begin
    state_next  = state_r;
    load_s      = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_en && !tx_empty) begin
          state_next = LEAD;
          load_s     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      LEAD: begin
        if (tick_s) state_next = SHIFT;
        else        state_next = LEAD;
      end
      SHIFT: begin
        if (tick_s && (edge_cnt_r == LAST_EDGE)) begin
          word_done_s = 1'b1;
          if (cfg_en && !tx_empty) begin
            state_next = SHIFT;
            load_s     = 1'b1;
          end else begin
            state_next = TRAIL;
          end
        end else begin
          state_next = SHIFT;
        end
      end
      TRAIL: begin
        if (tick_s) state_next = IDLE;
        else        state_next = TRAIL;
      end
      default: state_next = IDLE;
    endcase
  end

  // Chip-select targets, computed from the upcoming state so CS tracks the FSM exactly.
  always_comb begin
    cs_next_s = {CS_COUNT{1'b1}};
    for (int i = 0; i < CS_COUNT; i++) begin
      if (cfg_sel == 2'(i)) begin
        cs_next_s[i] = cfg_auto ? (state_next == IDLE) : ~cfg_man;
      end else begin
        cs_next_s[i] = 1'b1;
      end
    end
  end

  // Engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next;
  end

  // Shift datapath, divider and registered pad outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r  <= '0;
      cur_div_r  <= '0;
      edge_cnt_r <= '0;
      shift_r    <= '0;
      rx_r       <= '0;
      cur_cpol_r <= 1'b0;
      cur_cpha_r <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_r       <= {CS_COUNT{1'b1}};
    end else begin
      cs_r <= cs_next_s;
      if (state_r == IDLE || tick_s) div_cnt_r <= '0;
      else                           div_cnt_r <= div_cnt_r + 1'b1;
      if (load_s) begin
        shift_r    <= tx_dout;
        mosi_r     <= tx_dout[DATA_WIDTH-1];
        cur_div_r  <= cfg_div;
        cur_cpol_r <= cfg_cpol;
        cur_cpha_r <= cfg_cpha;
        edge_cnt_r <= '0;
        sclk_r     <= cfg_cpol;
      end else if (state_r == SHIFT && tick_s) begin
        edge_cnt_r <= edge_cnt_r + 1'b1;
        sclk_r     <= ~sclk_r;
        if (sample_s) rx_r <= {rx_r[DATA_WIDTH-2:0], spi_miso};
        if (shift_s) begin
          shift_r <= {shift_r[DATA_WIDTH-2:0], 1'b0};
          mosi_r  <= shift_r[DATA_WIDTH-2];
        end
      end else if (state_r == IDLE) begin
        sclk_r <= cfg_cpol;
      end
    end
  end

  assign spi_en   = cfg_en;
  assign spi_clk  = sclk_r;
  assign spi_mosi = mosi_r;
  assign spi_cs   = cs_r;

endmodule
